// File: rtl/inst_fetch_unit_pkg.sv
// Shared front-end definitions: fetch FSM encoding, NOP word and fetch-queue entry layout.
package inst_fetch_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    // Queue entry is {pc, inst, taken, target}, packed MSB first.
    localparam int FQ_PC_W     = XLEN;
    localparam int FQ_INST_W   = XLEN;
    localparam int FQ_TAKEN_W  = 1;
    localparam int FQ_TARGET_W = XLEN;
    localparam int FQ_ENTRY_W  = FQ_PC_W + FQ_INST_W + FQ_TAKEN_W + FQ_TARGET_W;

endpackage

// File: rtl/inst_fetch_queue.sv
// Synchronous FIFO with flush; head entry is read combinationally.
// Zero-latency head after push edge; pushes while full are dropped, flush wins over push/pop.
module inst_fetch_queue #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: one outstanding imem read, word returned to the PC generator, then queued for decode.
// inst_valid 1 cycle after response, dec_* 2 cycles; fetching parks in IDLE while the queue is full.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int FQ_DEPTH   = 4,
    parameter int FQ_WIDTH   = 2
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [ADDR_WIDTH-1:0] BOOT_ADDR,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  pc_taken_in,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [ADDR_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [ADDR_WIDTH-1:0] inst,
    output logic                  dec_valid,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    output logic [ADDR_WIDTH-1:0] dec_inst,
    output logic                  dec_taken,
    output logic [ADDR_WIDTH-1:0] dec_target,
    input  logic                  dec_ready
);

    localparam int ENTRY_W = 3*ADDR_WIDTH + FQ_TAKEN_W;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    fetch_state_t          state_q;
    fetch_state_t          state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [FQ_WIDTH:0]     fq_count;
    logic [FQ_WIDTH:0]     fq_count_nxt;
    logic                  fq_push;
    logic                  fq_pop;
    logic                  rsp_accept;
    logic [ENTRY_W-1:0]    fq_push_dat;
    logic [ENTRY_W-1:0]    fq_head_dat;

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = fetch_pc;
    assign rsp_accept     = (state_q == ST_WAIT) && imem_rsp_valid && !flush;

    assign fq_push     = inst_valid && !flush;
    assign fq_pop      = dec_valid && dec_ready && !flush;
    assign fq_push_dat = {inst_pc, inst, pc_taken_in, pc_in};
    assign dec_valid   = (fq_count != '0);
    assign {dec_pc, dec_inst, dec_taken, dec_target} = fq_head_dat;

    // Occupancy after this edge, so a word being pushed now blocks the next issue.
    always_comb begin
        fq_count_nxt = fq_count;
        if (flush) begin
            fq_count_nxt = '0;
        end else begin
            case ({fq_push, fq_pop})
                2'b10:   fq_count_nxt = fq_count + 1'b1;
                2'b01:   fq_count_nxt = fq_count - 1'b1;
                default: fq_count_nxt = fq_count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fq_count_nxt < (FQ_WIDTH+1)'(FQ_DEPTH)) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_nxt = flush ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = ST_IDLE;
                end else if (flush) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_IDLE;
            fetch_pc   <= BOOT_ADDR & ALIGN_MASK;
            inst_valid <= 1'b0;
            inst_pc    <= '0;
            inst       <= ADDR_WIDTH'(NOP_INST);
        end else begin
            state_q    <= state_nxt;
            inst_valid <= rsp_accept;
            if (rsp_accept) begin
                inst_pc <= fetch_pc;
                inst    <= imem_rsp_data;
            end
            if (flush) begin
                fetch_pc <= flush_pc & ALIGN_MASK;
            end else if (inst_valid) begin
                fetch_pc <= pc_in & ALIGN_MASK;
            end
        end
    end

    inst_fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (FQ_DEPTH),
        .PTR_W (FQ_WIDTH)
    ) u_fq (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .push     (fq_push),
        .push_dat (fq_push_dat),
        .pop      (fq_pop),
        .flush    (flush),
        .head_dat (fq_head_dat),
        .count    (fq_count)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: memory + PC-generator model drive stimulus, queues hold expectations.
module tb_inst_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    localparam logic [31:0] BOOT     = 32'h0000_1000;
    localparam logic [31:0] JAL_WORD = 32'h0080_006F;

    logic        CLK;
    logic        RSTN;
    logic [31:0] BOOT_ADDR;
    logic [31:0] pc_in;
    logic        pc_taken_in;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_taken;
    logic [31:0] dec_target;
    logic        dec_ready;

    inst_fetch_unit dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .BOOT_ADDR      (BOOT_ADDR),
        .pc_in          (pc_in),
        .pc_taken_in    (pc_taken_in),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst           (inst),
        .dec_valid      (dec_valid),
        .dec_pc         (dec_pc),
        .dec_inst       (dec_inst),
        .dec_taken      (dec_taken),
        .dec_target     (dec_target),
        .dec_ready      (dec_ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_1004) ? JAL_WORD : {a[19:0], 12'h013};
    endfunction

    // PC generator behaviour: jal +8 predicted taken, everything else falls through.
    function automatic ent_t make_ent(input logic [31:0] a);
        ent_t r;
        r.pc     = a;
        r.inst   = mem_word(a);
        r.taken  = (r.inst == JAL_WORD);
        r.target = a + (r.taken ? 32'd8 : 32'd4);
        return r;
    endfunction

    ent_t        exp_inst_q[$];
    ent_t        exp_dec_q[$];
    ent_t        cur;
    bit          exp_iv, exp_iv_next;
    bit          pend, pend_drop;
    int          pend_cnt, mem_lat;
    logic [31:0] pend_addr, exp_req_addr, last_acc_addr;
    int          cyc, resp_cyc, accepts, req_cycles;
    bit          chk_lat;
    logic        rstn_nxt, flush_nxt, ready_nxt, dec_ready_nxt;
    logic [31:0] flush_pc_nxt;

    task automatic step();
        ent_t e;
        @(posedge CLK);
        #1;
        cyc++;
        RSTN           = rstn_nxt;
        imem_req_ready = ready_nxt;
        dec_ready      = dec_ready_nxt;
        if (!RSTN) begin
            exp_inst_q.delete();
            exp_dec_q.delete();
            exp_iv       = 1'b0;
            exp_iv_next  = 1'b0;
            pend_drop    = 1'b1;
            exp_req_addr = BOOT & ~32'h3;
        end else begin
            exp_iv      = exp_iv_next;
            exp_iv_next = 1'b0;
        end
        flush     = flush_nxt;
        flush_pc  = flush_pc_nxt;
        flush_nxt = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                pend           = 1'b0;
                if (!pend_drop && !flush && RSTN) begin
                    exp_inst_q.push_back(make_ent(pend_addr));
                    exp_iv_next = 1'b1;
                    resp_cyc    = cyc;
                end
            end else begin
                pend_cnt--;
            end
        end
        if (flush) pend_drop = 1'b1;
        if (exp_iv && exp_inst_q.size() > 0) begin
            cur         = exp_inst_q[0];
            pc_in       = cur.target;
            pc_taken_in = cur.taken;
        end else begin
            pc_in       = $urandom;
            pc_taken_in = 1'($urandom_range(0, 1));
        end

        @(negedge CLK);
        if (RSTN) begin
            chk_eq("inst_valid", 32'(inst_valid), 32'(exp_iv));
            if (inst_valid && exp_inst_q.size() > 0) begin
                e = exp_inst_q.pop_front();
                chk_eq("inst_pc", inst_pc, e.pc);
                chk_eq("inst", inst, e.inst);
            end
            chk_eq("dec_valid", 32'(dec_valid), 32'(exp_dec_q.size() != 0));
            if (dec_valid && dec_ready && exp_dec_q.size() > 0) begin
                chk_eq("dec_pc", dec_pc, exp_dec_q[0].pc);
                chk_eq("dec_inst", dec_inst, exp_dec_q[0].inst);
                chk_eq("dec_taken", 32'(dec_taken), 32'(exp_dec_q[0].taken));
                chk_eq("dec_target", dec_target, exp_dec_q[0].target);
            end
            if (imem_req_valid) begin
                req_cycles++;
                chk_eq("req_addr", imem_req_addr, exp_req_addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                chk_eq("one_outstanding", 32'(pend), 32'd0);
                if (chk_lat && resp_cyc > 0) chk_eq("issue_after_rsp", 32'(cyc - resp_cyc), 32'd2);
                pend          = 1'b1;
                pend_cnt      = mem_lat;
                pend_drop     = flush;
                pend_addr     = exp_req_addr;
                last_acc_addr = exp_req_addr;
                accepts++;
            end
            if (flush) begin
                exp_dec_q.delete();
                exp_req_addr = flush_pc & ~32'h3;
            end else begin
                if (dec_ready && exp_dec_q.size() > 0) void'(exp_dec_q.pop_front());
                if (exp_iv) begin
                    exp_dec_q.push_back(cur);
                    exp_req_addr = cur.target & ~32'h3;
                end
            end
        end
    endtask

    task automatic chk_reset_vals();
        chk_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk_eq("rst_req_addr", imem_req_addr, BOOT);
        chk_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk_eq("rst_inst_pc", inst_pc, 32'd0);
        chk_eq("rst_inst", inst, 32'h0000_0013);
        chk_eq("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk_eq("rst_dec_pc", dec_pc, 32'd0);
        chk_eq("rst_dec_inst", dec_inst, 32'd0);
        chk_eq("rst_dec_taken", 32'(dec_taken), 32'd0);
        chk_eq("rst_dec_target", dec_target, 32'd0);
    endtask

    task automatic wait_accept(input string tag);
        int acc0;
        acc0 = accepts;
        for (int i = 0; i < 50 && accepts == acc0; i++) step();
        chk_eq(tag, 32'(accepts != acc0), 32'd1);
    endtask

    initial begin
        int acc0, rc, exp_fetch;
        RSTN = 1'b0; rstn_nxt = 1'b0;
        BOOT_ADDR = BOOT;
        flush = 1'b0; flush_nxt = 1'b0; flush_pc = '0; flush_pc_nxt = '0;
        imem_req_ready = 1'b1; ready_nxt = 1'b1;
        dec_ready = 1'b1; dec_ready_nxt = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        pc_in = '0; pc_taken_in = 1'b0;
        exp_iv = 0; exp_iv_next = 0; pend = 0; pend_drop = 0; pend_cnt = 0;
        mem_lat = 1; exp_req_addr = BOOT; last_acc_addr = '0; pend_addr = '0;
        cyc = 0; resp_cyc = 0; accepts = 0; req_cycles = 0; chk_lat = 0;
        cur = '0;

        step();
        step();
        chk_reset_vals();

        // Release: IDLE for one cycle, then the first request at BOOT_ADDR.
        rstn_nxt = 1'b1;
        step();
        chk_eq("first_cycle_idle", 32'(imem_req_valid), 32'd0);
        step();
        chk_eq("second_cycle_req", 32'(imem_req_valid), 32'd1);

        // Sequential fetch through the jal at 0x1004 with a 1-cycle memory.
        chk_lat = 1'b1;
        for (int i = 0; i < 16; i++) step();
        chk_lat = 1'b0;

        // Decode stalled: queue fills to depth and fetch parks.
        dec_ready_nxt = 1'b0;
        step();
        exp_fetch = 4 - exp_dec_q.size() - int'(pend && !pend_drop) - int'(exp_iv_next);
        acc0 = accepts;
        for (int i = 0; i < 20; i++) step();
        rc = req_cycles;
        for (int i = 0; i < 10; i++) step();
        chk_eq("full_fetch_count", 32'(accepts - acc0), 32'(exp_fetch));
        chk_eq("parked_no_req", 32'(req_cycles - rc), 32'd0);
        dec_ready_nxt = 1'b1;
        step();
        dec_ready_nxt = 1'b0;
        acc0 = accepts;
        for (int i = 0; i < 15; i++) step();
        chk_eq("one_pop_one_fetch", 32'(accepts - acc0), 32'd1);
        dec_ready_nxt = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // Flush while waiting; the response lands 3 cycles later and is dropped.
        mem_lat = 4;
        wait_accept("wait_accept_flushwait");
        flush_nxt = 1'b1; flush_pc_nxt = 32'h0000_2000;
        step();
        acc0 = accepts;
        for (int i = 0; i < 3; i++) step();
        chk_eq("drop_no_issue", 32'(accepts - acc0), 32'd0);
        chk_eq("drop_dec_valid", 32'(dec_valid), 32'd0);
        mem_lat = 1;
        wait_accept("wait_accept_after_drop");
        chk_eq("refetch_flush_pc", last_acc_addr, 32'h0000_2000);
        for (int i = 0; i < 8; i++) step();

        // Flush while a request is stalled by ready low: retarget, no drop.
        ready_nxt = 1'b0;
        for (int i = 0; i < 20 && !(imem_req_valid && !imem_req_ready); i++) step();
        chk_eq("stalled_in_req", 32'(imem_req_valid && !imem_req_ready), 32'd1);
        flush_nxt = 1'b1; flush_pc_nxt = 32'h0000_3002;
        step();
        step();
        chk_eq("retarget_valid", 32'(imem_req_valid), 32'd1);
        chk_eq("retarget_addr", imem_req_addr, 32'h0000_3000);
        ready_nxt = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Reset during WAIT with decode stalled; late response must be ignored.
        mem_lat = 2;
        dec_ready_nxt = 1'b0;
        wait_accept("wait_accept_rstwait");
        ready_nxt = 1'b0;
        rstn_nxt  = 1'b0;
        step();
        chk_reset_vals();
        rstn_nxt = 1'b1;
        step();
        chk_eq("post_rst_idle", 32'(imem_req_valid), 32'd0);
        step();
        chk_eq("post_rst_req", 32'(imem_req_valid), 32'd1);
        chk_eq("post_rst_addr", imem_req_addr, BOOT);
        ready_nxt = 1'b1; dec_ready_nxt = 1'b1; mem_lat = 1;
        for (int i = 0; i < 12; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
